pc_sequencer: RTL and testbench

Next-PC controller for the 5-stage pipelined CPU. Drives the D input of the free-running program-counter register, which has no enable, so every hold is done by recirculating pc_cur. Arbitrates between the redirect sources (exception, EX-stage branch, ID-stage jump), the load-use stall, and instruction-memory wait states. Generates the IF/ID and ID/EX flush strobes and a redirect performance counter.

---
 rtl/pc_sequencer_pkg.sv | 31 +++
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer_redirect_arb.sv | 31 +++
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the next-PC controller
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  // Numeric order of the codes is the redirect priority order.
  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_JUMP   = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_EXC    = 2'd3
  } src_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

  function automatic logic src_outranks_or_ties(input src_t a, input src_t b);
    return a >= b;
  endfunction

  // Jumps resolve in ID, so only EX-stage and exception redirects kill ID/EX.
  function automatic logic src_flushes_id(input src_t s);
    return (s == SRC_EXC) || (s == SRC_BRANCH);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - pipeline-side signal bundle of the next-PC controller
interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic        imem_ready;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        exception;
  logic        halt;
  logic [31:0] pc_next;
  logic        fetch_valid;
  logic        flush_if;
  logic        flush_id;

  modport master (
    output pc_cur, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target, exception, halt,
    input  pc_next, fetch_valid, flush_if, flush_id
  );

  modport slave (
    input  pc_cur, imem_ready, stall, branch_taken, branch_target,
           jump, jump_target, exception, halt,
    output pc_next, fetch_valid, flush_if, flush_id
  );
endinterface

// File: rtl/pc_sequencer_redirect_arb.sv
// rtl/pc_sequencer_redirect_arb.sv - priority encoder over exception, branch and jump redirects
module redirect_arb
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        exception,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output src_t        src,
  output logic [31:0] target
);

  always_comb begin
    src    = SRC_NONE;
    target = 32'h0000_0000;
    if (exception) begin
      src    = SRC_EXC;
      target = EXC_VECTOR;
    end else if (branch_taken) begin
      src    = SRC_BRANCH;
      target = branch_target;
    end else if (jump) begin
      src    = SRC_JUMP;
      target = jump_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC controller: redirect arbitration, stall/wait holds, flushes
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int          CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  pc_sequencer_if.slave    bus,
  output logic [CNT_W-1:0] redirect_count
);

  state_t      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  src_t        pend_src_q, pend_src_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [CNT_W-1:0] count_q;
  logic        count_inc;

  src_t        redir_src;
  logic [31:0] redir_target;
  logic        redirect;
  logic        take_new;
  logic        run_like;

  logic [31:0] pc_next_c;
  logic        fetch_valid_c, flush_if_c, flush_id_c;

  redirect_arb #(.EXC_VECTOR(EXC_VECTOR)) u_arb (
    .exception     (bus.exception),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .src           (redir_src),
    .target        (redir_target)
  );

  assign redirect = (redir_src != SRC_NONE);
  assign take_new = redirect && (!pend_valid_q || src_outranks_or_ties(redir_src, pend_src_q));

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_src_d    = pend_src_q;
    pend_target_d = pend_target_q;
    pc_next_c     = bus.pc_cur;
    fetch_valid_c = 1'b0;
    flush_if_c    = 1'b0;
    flush_id_c    = 1'b0;
    count_inc     = 1'b0;
    run_like      = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        pc_next_c = RESET_VECTOR;
        state_d   = ST_RUN;
      end
      ST_RUN: run_like = 1'b1;
      ST_WAIT: begin
        if (redirect) begin
          flush_if_c = 1'b1;
          flush_id_c = src_flushes_id(redir_src);
        end
        if (bus.imem_ready) begin
          // The word returned now belongs to the old path, so it is never latched.
          if (pend_valid_q || redirect) begin
            pc_next_c    = take_new ? redir_target : pend_target_q;
            pend_valid_d = 1'b0;
            pend_src_d   = SRC_NONE;
            count_inc    = 1'b1;
            state_d      = ST_RUN;
          end else begin
            run_like = 1'b1;
          end
        end else if (take_new) begin
          pend_valid_d  = 1'b1;
          pend_src_d    = redir_src;
          pend_target_d = redir_target;
        end
      end
      ST_HALT: begin
        if (bus.exception) begin
          pc_next_c  = EXC_VECTOR;
          flush_if_c = 1'b1;
          flush_id_c = 1'b1;
          count_inc  = 1'b1;
          state_d    = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (run_like) begin
      state_d = ST_RUN;
      if (redirect) begin
        pc_next_c  = redir_target;
        flush_if_c = 1'b1;
        flush_id_c = src_flushes_id(redir_src);
        count_inc  = 1'b1;
      end else if (bus.halt) begin
        state_d = ST_HALT;
      end else if (!bus.stall) begin
        if (!bus.imem_ready) begin
          state_d = ST_WAIT;
        end else begin
          pc_next_c     = bus.pc_cur + 32'd4;
          fetch_valid_c = 1'b1;
        end
      end
    end

    if (reset) begin
      pc_next_c     = RESET_VECTOR;
      fetch_valid_c = 1'b0;
      flush_if_c    = 1'b0;
      flush_id_c    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pend_valid_q  <= 1'b0;
      pend_src_q    <= SRC_NONE;
      pend_target_q <= 32'h0000_0000;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_src_q    <= pend_src_d;
      pend_target_q <= pend_target_d;
      if (count_inc && (count_q != {CNT_W{1'b1}})) begin
        count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.pc_next     = pc_next_c;
  assign bus.fetch_valid = fetch_valid_c;
  assign bus.flush_if    = flush_if_c;
  assign bus.flush_id    = flush_id_c;
  assign redirect_count  = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with directed and random traffic
module tb_pc_sequencer;

  localparam int          CNT_W   = 5;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] RV      = 32'h0000_0000;
  localparam logic [31:0] EV      = 32'h0000_0080;

  typedef enum {M_BOOT, M_RUN, M_WAIT, M_HALT} mode_t;

  typedef struct {
    logic [31:0] pc;
    logic        fv, fi, fd;
    int          cnt;
    bit          dir;
    logic [31:0] dpc;
    logic        dfv, dfi, dfd;
    int          dcnt;
  } exp_t;

  logic             clock;
  logic             reset;
  logic [CNT_W-1:0] redirect_count;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_VECTOR(RV), .EXC_VECTOR(EV), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .redirect_count (redirect_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state: pending redirect kept as a rank (0 = none) and a target.
  mode_t       mode     = M_BOOT;
  int          pend_rank = 0;
  logic [31:0] pend_tgt = 32'h0;
  int          cnt      = 0;
  logic [31:0] m_pc     = RV;

  bit          dir_set = 0;
  logic [31:0] dir_pc;
  logic        dir_fv, dir_fi, dir_fd;
  int          dir_cnt;

  task automatic bump();
    if (cnt < CNT_MAX) cnt++;
  endtask

  task automatic run_rules(input int rank, input logic [31:0] tgt, inout exp_t e);
    mode = M_RUN;
    if (rank > 0) begin
      e.pc = tgt; e.fi = 1'b1; e.fd = (rank >= 2); bump();
    end else if (bus.halt) begin
      mode = M_HALT;
    end else if (!bus.stall) begin
      if (!bus.imem_ready) mode = M_WAIT;
      else begin e.pc = bus.pc_cur + 32'd4; e.fv = 1'b1; end
    end
  endtask

  task automatic model_step(output exp_t e);
    int          rank;
    logic [31:0] tgt;
    rank = bus.exception ? 3 : bus.branch_taken ? 2 : bus.jump ? 1 : 0;
    tgt  = bus.exception ? EV : bus.branch_taken ? bus.branch_target :
           bus.jump ? bus.jump_target : 32'h0;
    e = '{pc: bus.pc_cur, fv: 1'b0, fi: 1'b0, fd: 1'b0, cnt: 0, dir: 1'b0,
          dpc: 32'h0, dfv: 1'b0, dfi: 1'b0, dfd: 1'b0, dcnt: -1};
    if (reset) begin
      mode = M_BOOT; pend_rank = 0; pend_tgt = 32'h0; cnt = 0; e.pc = RV;
    end else begin
      case (mode)
        M_BOOT: begin e.pc = RV; mode = M_RUN; end
        M_RUN:  run_rules(rank, tgt, e);
        M_WAIT: begin
          if (rank > 0) begin
            e.fi = 1'b1; e.fd = (rank >= 2);
            if (pend_rank == 0 || rank >= pend_rank) begin pend_rank = rank; pend_tgt = tgt; end
          end
          if (bus.imem_ready) begin
            if (pend_rank > 0) begin
              e.pc = pend_tgt; pend_rank = 0; bump(); mode = M_RUN;
            end else begin
              run_rules(0, 32'h0, e);
            end
          end
        end
        M_HALT: begin
          if (bus.exception) begin
            e.pc = EV; e.fi = 1'b1; e.fd = 1'b1; bump(); mode = M_RUN;
          end
        end
        default: mode = M_BOOT;
      endcase
    end
  endtask

  task automatic dir(input logic [31:0] pc, input logic fv, fi, fd, input int c);
    dir_set = 1; dir_pc = pc; dir_fv = fv; dir_fi = fi; dir_fd = fd; dir_cnt = c;
  endtask

  task automatic cyc(input logic rst, rdy, stl, br, input logic [31:0] bt,
                     input logic jmp, input logic [31:0] jt, input logic exc, hlt);
    exp_t e;
    int   c;
    @(posedge clock); #1;
    bus.pc_cur = m_pc; reset = rst; bus.imem_ready = rdy; bus.stall = stl;
    bus.branch_taken = br; bus.branch_target = bt; bus.jump = jmp; bus.jump_target = jt;
    bus.exception = exc; bus.halt = hlt;
    c = reset ? 0 : cnt;
    model_step(e);
    e.cnt = c;
    m_pc = e.pc;
    if (dir_set) begin
      e.dir = 1'b1; e.dpc = dir_pc; e.dfv = dir_fv; e.dfi = dir_fi; e.dfd = dir_fd; e.dcnt = dir_cnt;
      dir_set = 0;
    end
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc_next", bus.pc_next, e.pc);
        check("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, e.fv});
        check("flush_if", {31'b0, bus.flush_if}, {31'b0, e.fi});
        check("flush_id", {31'b0, bus.flush_id}, {31'b0, e.fd});
        check("redirect_count", 32'(redirect_count), 32'(e.cnt));
        if (e.dir) begin
          check("dir_pc_next", bus.pc_next, e.dpc);
          check("dir_fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, e.dfv});
          check("dir_flush_if", {31'b0, bus.flush_if}, {31'b0, e.dfi});
          check("dir_flush_id", {31'b0, bus.flush_id}, {31'b0, e.dfd});
          if (e.dcnt >= 0) check("dir_redirect_count", 32'(redirect_count), 32'(e.dcnt));
        end
      end
    end
  end

  function automatic logic [31:0] rnd_tgt();
    return ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
  endfunction

  initial begin : driver
    reset = 1'b1; bus.pc_cur = RV; bus.imem_ready = 1'b0; bus.stall = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 32'h0; bus.jump = 1'b0;
    bus.jump_target = 32'h0; bus.exception = 1'b0; bus.halt = 1'b0;

    dir(RV, 0, 0, 0, 0); cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    // boot then sequential fetch
    dir(32'h0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      dir(32'(4 * i), 1, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // branch beats jump at pc 0x20
    dir(32'h100, 0, 1, 1, 0); cyc(0, 1, 0, 1, 32'h100, 1, 32'h200, 0, 0);
    dir(32'h40, 0, 1, 0, 1); cyc(0, 1, 0, 0, 0, 1, 32'h40, 0, 0);
    // load-use stall
    for (int i = 0; i < 3; i++) begin
      dir(32'h40, 0, 0, 0, 2); cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    end
    dir(32'h44, 1, 0, 0, 2); cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // wait state with a pending jump
    cyc(0, 1, 0, 0, 0, 1, 32'h60, 0, 0);
    dir(32'h60, 0, 0, 0, 3); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    dir(32'h60, 0, 1, 0, 3); cyc(0, 0, 0, 0, 0, 1, 32'h300, 0, 0);
    dir(32'h60, 0, 0, 0, 3); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    dir(32'h300, 0, 0, 0, 3); cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    dir(32'h304, 1, 0, 0, 4); cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // halt ignores branches; exception exits
    cyc(0, 1, 0, 0, 0, 1, 32'h80, 0, 0);
    dir(32'h80, 0, 0, 0, 5); cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      dir(32'h80, 0, 0, 0, 5); cyc(0, 1, 0, (i % 2 == 0), 32'h900, 0, 0, 0, 0);
    end
    dir(EV, 0, 1, 1, 5); cyc(0, 1, 0, 0, 0, 0, 0, 1, 0);
    dir(32'h84, 1, 0, 0, 6); cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    // reset in WAIT discards pending redirect
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    dir(32'h84, 0, 1, 0, 6); cyc(0, 0, 0, 0, 0, 1, 32'h500, 0, 0);
    dir(RV, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 1, 32'h500, 0, 0);
    dir(RV, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    dir(32'h4, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(499) == 0, $urandom_range(99) < 80, $urandom_range(99) < 15,
          $urandom_range(99) < 10, rnd_tgt(), $urandom_range(99) < 10, rnd_tgt(),
          $urandom_range(99) < 4, $urandom_range(99) < 3);
    end

    @(negedge clock); #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
